// File: rtl/execute_stage_x_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch and mul/div funct3,
// forward selects and the mul/div sequencer state.
package execute_stage_x_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_t;

endpackage

// File: rtl/exe_muldiv.sv
// Iterative multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle for XLEN cycles, sign applied on the way out.
module exe_muldiv
  import execute_stage_x_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;

  md_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic [XLEN-1:0] hi, lo, opnd, dividend;
  logic            neg_q, neg_r, b_zero;

  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_sh;
  logic            div_ge;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    sa      = a[XLEN-1] & (funct3 != MD_MULHU) & (funct3 != MD_DIVU) & (funct3 != MD_REMU);
    sb      = b[XLEN-1] & ((funct3 == MD_MUL) | (funct3 == MD_MULH) |
                           (funct3 == MD_DIV) | (funct3 == MD_REM));
    mag_a   = sa ? -a : a;
    mag_b   = sb ? -b : b;
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_sh  = {hi, lo[XLEN-1]};
    div_ge  = div_sh >= {1'b0, opnd};
    prod    = neg_q ? -{hi, lo} : {hi, lo};
  end

  always_comb begin
    result = '0;
    case (op)
      MD_MUL:                        result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               result = b_zero ? '1 : (neg_q ? -lo : lo);
      default:                       result = b_zero ? dividend : (neg_r ? -hi : hi);
    endcase
  end

  // Launch cycle counts as busy so the hazard unit freezes E before the op latches.
  assign busy = ~rst & ((state == MD_BUSY) | ((state == MD_IDLE) & start));
  assign done = (state == MD_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      op       <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      dividend <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      b_zero   <= 1'b0;
    end else if (flush) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          state    <= MD_BUSY;
          cnt      <= '0;
          op       <= funct3;
          hi       <= '0;
          dividend <= a;
          b_zero   <= (b == '0);
          neg_q    <= sa ^ sb;
          neg_r    <= sa;
          // Divide shifts the dividend out of lo; multiply shifts the multiplier out.
          lo       <= funct3[2] ? mag_a : mag_b;
          opnd     <= funct3[2] ? mag_b : mag_a;
        end
        MD_BUSY: begin
          if (op[2]) begin
            hi <= div_ge ? XLEN'(div_sh - {1'b0, opnd}) : div_sh[XLEN-1:0];
            lo <= {lo[XLEN-2:0], div_ge};
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) state <= MD_DONE;
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage_x.sv
// Execute stage: operand forwarding, ALU, branch resolution, optional iterative
// mul/div and the EX/MEM pipeline register.
module execute_stage_x
  import execute_stage_x_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_e,
  input  logic            flush_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic            jalr_e,
  input  logic            alu_src_e,
  input  logic [1:0]      result_src_e,
  input  logic [3:0]      alu_ctrl_e,
  input  logic [2:0]      funct3_e,
  input  logic            md_valid_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc4_e,
  input  logic [4:0]      rd_e,
  input  logic [1:0]      fwd_a_e,
  input  logic [1:0]      fwd_b_e,
  input  logic [XLEN-1:0] result_w,
  output logic            stall_e,
  output logic            pcsrc_e,
  output logic [XLEN-1:0] pctarget_e,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m,
  output logic [4:0]      rd_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc4_m
);
  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] src_a, src_b, alu_b, alu_y, jalr_sum, md_result;
  logic [SW-1:0]   shamt;
  logic            cond, md_start, md_done, load;

  always_comb begin
    case (fwd_a_e)
      FWD_W:   src_a = result_w;
      FWD_M:   src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
    case (fwd_b_e)
      FWD_W:   src_b = result_w;
      FWD_M:   src_b = alu_result_m;
      default: src_b = rd2_e;
    endcase
    alu_b = alu_src_e ? imm_e : src_b;
    shamt = alu_b[SW-1:0];
  end

  always_comb begin
    case (alu_ctrl_e)
      ALU_ADD:  alu_y = src_a + alu_b;
      ALU_SUB:  alu_y = src_a - alu_b;
      ALU_AND:  alu_y = src_a & alu_b;
      ALU_OR:   alu_y = src_a | alu_b;
      ALU_XOR:  alu_y = src_a ^ alu_b;
      ALU_SLT:  alu_y = XLEN'($signed(src_a) < $signed(alu_b));
      ALU_SLTU: alu_y = XLEN'(src_a < alu_b);
      ALU_SLL:  alu_y = src_a << shamt;
      ALU_SRL:  alu_y = src_a >> shamt;
      ALU_SRA:  alu_y = $unsigned($signed(src_a) >>> shamt);
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    case (funct3_e)
      BR_BEQ:  cond = (src_a == src_b);
      BR_BNE:  cond = (src_a != src_b);
      BR_BLT:  cond = ($signed(src_a) <  $signed(src_b));
      BR_BGE:  cond = ($signed(src_a) >= $signed(src_b));
      BR_BLTU: cond = (src_a <  src_b);
      BR_BGEU: cond = (src_a >= src_b);
      default: cond = 1'b0;
    endcase
  end

  assign jalr_sum   = src_a + imm_e;
  assign pcsrc_e    = valid_e & ~flush_e & (jump_e | (branch_e & cond));
  assign pctarget_e = jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_e + imm_e);

  assign md_start = (MD_EN != 0) & valid_e & md_valid_e & ~flush_e;

  exe_muldiv #(.XLEN(XLEN)) u_md (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .flush  (flush_e),
    .funct3 (funct3_e),
    .a      (src_a),
    .b      (src_b),
    .busy   (stall_e),
    .done   (md_done),
    .result (md_result)
  );

  // Anything that is not a live, unstalled instruction becomes a bubble;
  // only the write enables are cleared, the data fields keep their last value.
  assign load = valid_e & ~flush_e & ~stall_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
      rd_m         <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc4_m        <= '0;
    end else begin
      reg_write_m <= load & reg_write_e;
      mem_write_m <= load & mem_write_e;
      if (load) begin
        result_src_m <= result_src_e;
        rd_m         <= rd_e;
        alu_result_m <= md_done ? md_result : alu_y;
        write_data_m <= src_b;
        pc4_m        <= pc4_e;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_x.sv
// Bench for execute_stage_x: directed scenarios then random ALU/branch and
// mul/div traffic against an arithmetic reference model.
module tb_execute_stage_x;
  import execute_stage_x_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_e, flush_e, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e;
  logic [1:0]  result_src_e;
  logic [3:0]  alu_ctrl_e;
  logic [2:0]  funct3_e;
  logic        md_valid_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e, result_w;
  logic [4:0]  rd_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        stall_e, pcsrc_e, reg_write_m, mem_write_m;
  logic [31:0] pctarget_e, alu_result_m, write_data_m, pc4_m;
  logic [1:0]  result_src_m;
  logic [4:0]  rd_m;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_alu, m_wd;
  logic        m_rw, m_mw;
  logic [4:0]  m_rd;

  execute_stage_x #(.XLEN(32), .MD_EN(1)) dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .branch_e(branch_e),
    .jump_e(jump_e), .jalr_e(jalr_e), .alu_src_e(alu_src_e),
    .result_src_e(result_src_e), .alu_ctrl_e(alu_ctrl_e), .funct3_e(funct3_e),
    .md_valid_e(md_valid_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .pc_e(pc_e), .pc4_e(pc4_e), .rd_e(rd_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .result_w(result_w), .stall_e(stall_e), .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
    .rd_m(rd_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m), .pc4_m(pc4_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_e = 0; flush_e = 0; reg_write_e = 0; mem_write_e = 0; branch_e = 0;
    jump_e = 0; jalr_e = 0; alu_src_e = 0; result_src_e = 0; alu_ctrl_e = 0;
    funct3_e = 0; md_valid_e = 0; rd1_e = 0; rd2_e = 0; imm_e = 0; pc_e = 0;
    pc4_e = 0; rd_e = 0; fwd_a_e = 0; fwd_b_e = 0; result_w = 0;
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint w;
    sa = a; sb = b;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a * (32'd1 << b[4:0]);
      ALU_SRL:  return a / (32'd1 << b[4:0]);
      ALU_SRA: begin
        // floor division by a power of two
        w = longint'(sa);
        w = (w >= 0) ? (w / (64'sd1 << b[4:0])) : -((-w + (64'sd1 << b[4:0]) - 1) / (64'sd1 << b[4:0]));
        return w[31:0];
      end
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (f)
      BR_BEQ:  return a == b;
      BR_BNE:  return a != b;
      BR_BLT:  return sa < sb;
      BR_BGE:  return sa >= sb;
      BR_BLTU: return a < b;
      BR_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] ua64, ub64, up;
    int ia, ib, r;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ua64 = {32'd0, a}; ub64 = {32'd0, b};
    ia = a; ib = b;
    case (f)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin up = ua64 * ub64; return up[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        r = ia / ib; return r;
      end
      MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = ia % ib; return r;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_md(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int ns;
    logic bad;
    logic [31:0] exp;
    exp = md_ref(f, a, b);
    idle_in();
    valid_e = 1; md_valid_e = 1; reg_write_e = 1; funct3_e = f;
    rd1_e = a; rd2_e = b; rd_e = 5'd9;
    #1;
    ns = 0; bad = 0;
    while (stall_e === 1'b1 && ns < 100) begin
      ns++;
      tick();
      if (reg_write_m !== 1'b0) bad = 1;
    end
    chk({tag, "_stall_cycles"}, ns, 33);
    chk({tag, "_bubble"}, {31'd0, bad}, 32'd0);
    tick();
    chk({tag, "_result"}, alu_result_m, exp);
    chk({tag, "_rw"}, {31'd0, reg_write_m}, 32'd1);
    idle_in();
  endtask

  logic [31:0] a, b, imm, rw, pc, sa, sb, bb, exp_t;
  logic [3:0]  op;
  logic [1:0]  fa, fb;
  logic        v, f, exp_pc;

  initial begin
    idle_in();
    rst = 1;
    #12;
    chk("rst_rw", {31'd0, reg_write_m}, 0);
    chk("rst_alu", alu_result_m, 0);
    chk("rst_stall", {31'd0, stall_e}, 0);
    @(negedge clk);
    rst = 0;
    tick();

    // ADD 5 + 7
    idle_in(); valid_e = 1; reg_write_e = 1; alu_ctrl_e = ALU_ADD; rd1_e = 5; imm_e = 7; alu_src_e = 1;
    #1;
    chk("add_stall", {31'd0, stall_e}, 0);
    tick();
    chk("add_result", alu_result_m, 12);
    chk("add_stall_after", {31'd0, stall_e}, 0);

    // BLTU taken, BLT not taken on the same operands
    idle_in(); valid_e = 1; branch_e = 1; funct3_e = BR_BLTU; rd1_e = 1; rd2_e = 32'hFFFF_FFFF;
    pc_e = 32'h100; imm_e = 32'h20;
    #1;
    chk("bltu_pcsrc", {31'd0, pcsrc_e}, 1);
    chk("bltu_target", pctarget_e, 32'h120);
    funct3_e = BR_BLT;
    #1;
    chk("blt_pcsrc", {31'd0, pcsrc_e}, 0);
    jalr_e = 1; jump_e = 1; rd1_e = 32'h1001; imm_e = 32'h10;
    #1;
    chk("jalr_target", pctarget_e, 32'h1010);
    tick();

    // forwarding: A from alu_result_m (9), B from result_w (3)
    idle_in(); valid_e = 1; reg_write_e = 1; alu_ctrl_e = ALU_ADD; rd1_e = 4; imm_e = 5; alu_src_e = 1;
    tick();
    idle_in(); valid_e = 1; reg_write_e = 1; alu_ctrl_e = ALU_SUB; fwd_a_e = FWD_M; fwd_b_e = FWD_W;
    rd1_e = 32'hDEAD; rd2_e = 32'hBEEF; result_w = 3; rd_e = 3; pc4_e = 32'h80; result_src_e = 1;
    tick();
    chk("fwd_sub", alu_result_m, 6);
    chk("fwd_wd", write_data_m, 3);

    // reset in the middle of a divide
    idle_in(); valid_e = 1; md_valid_e = 1; reg_write_e = 1; funct3_e = MD_DIV; rd1_e = 100; rd2_e = 7;
    repeat (5) tick();
    rst = 1;
    #1;
    chk("rstmid_stall", {31'd0, stall_e}, 0);
    chk("rstmid_rw", {31'd0, reg_write_m}, 0);
    chk("rstmid_rd", {27'd0, rd_m}, 0);
    chk("rstmid_rs", {30'd0, result_src_m}, 0);
    chk("rstmid_wd", write_data_m, 0);
    chk("rstmid_pc4", pc4_m, 0);
    chk("rstmid_alu", alu_result_m, 0);
    @(negedge clk);
    rst = 0;
    idle_in(); valid_e = 1; reg_write_e = 1; alu_ctrl_e = ALU_ADD; rd1_e = 1; rd2_e = 2;
    #1;
    chk("postrst_stall", {31'd0, stall_e}, 0);
    @(posedge clk); #1;
    chk("postrst_add", alu_result_m, 3);

    run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("divu_z", MD_DIVU, 7, 0);
    run_md("rem_z", MD_REM, 7, 0);
    run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // flush at BUSY cycle 10
    idle_in(); valid_e = 1; md_valid_e = 1; reg_write_e = 1; funct3_e = MD_DIV; rd1_e = 100; rd2_e = 7;
    repeat (10) tick();
    flush_e = 1;
    tick();
    idle_in(); valid_e = 1; reg_write_e = 1; alu_ctrl_e = ALU_ADD; rd1_e = 20; imm_e = 22; alu_src_e = 1;
    #1;
    chk("flush_stall", {31'd0, stall_e}, 0);
    chk("flush_bubble", {31'd0, reg_write_m}, 0);
    @(posedge clk); #1;
    chk("flush_add", alu_result_m, 42);
    chk("flush_add_rw", {31'd0, reg_write_m}, 1);
    idle_in();
    repeat (3) tick();
    chk("flush_no_md", alu_result_m, 42);
    chk("flush_no_md_rw", {31'd0, reg_write_m}, 0);

    // known EX/MEM contents before random traffic
    idle_in(); valid_e = 1;
    tick();
    m_alu = 0; m_wd = 0; m_rw = 0; m_mw = 0; m_rd = 0;

    for (int i = 0; i < 40; i++) begin
      idle_in();
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom; imm = $urandom; rw = $urandom; pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) b = a;
      fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
      v = ($urandom_range(0, 7) != 0); f = ($urandom_range(0, 7) == 0);
      valid_e = v; flush_e = f; alu_ctrl_e = op; rd1_e = a; rd2_e = b; imm_e = imm;
      alu_src_e = 1'($urandom_range(0, 1)); fwd_a_e = fa; fwd_b_e = fb; result_w = rw;
      reg_write_e = 1'($urandom_range(0, 1)); mem_write_e = 1'($urandom_range(0, 1));
      branch_e = 1'($urandom_range(0, 1)); jump_e = ($urandom_range(0, 3) == 0);
      jalr_e = 1'($urandom_range(0, 1)); funct3_e = 3'($urandom_range(0, 7));
      pc_e = pc; pc4_e = pc + 4; rd_e = 5'($urandom_range(0, 31));
      sa = (fa == FWD_M) ? m_alu : (fa == FWD_W) ? rw : a;
      sb = (fb == FWD_M) ? m_alu : (fb == FWD_W) ? rw : b;
      bb = alu_src_e ? imm : sb;
      exp_pc = v & ~f & (jump_e | (branch_e & br_ref(funct3_e, sa, sb)));
      exp_t = jalr_e ? ((sa + imm) & 32'hFFFF_FFFE) : (pc + imm);
      #1;
      chk("rnd_pcsrc", {31'd0, pcsrc_e}, {31'd0, exp_pc});
      chk("rnd_target", pctarget_e, exp_t);
      if (v && !f) begin
        m_alu = alu_ref(op, sa, bb); m_wd = sb; m_rd = rd_e;
        m_rw = reg_write_e; m_mw = mem_write_e;
      end else begin
        m_rw = 0; m_mw = 0;
      end
      @(posedge clk); #1;
      chk("rnd_alu", alu_result_m, m_alu);
      chk("rnd_wd", write_data_m, m_wd);
      chk("rnd_rd", {27'd0, rd_m}, {27'd0, m_rd});
      chk("rnd_rw", {31'd0, reg_write_m}, {31'd0, m_rw});
      chk("rnd_mw", {31'd0, mem_write_m}, {31'd0, m_mw});
    end

    for (int i = 0; i < 10; i++) begin
      logic [31:0] pa, pb;
      case ($urandom_range(0, 7))
        0: pa = 32'h8000_0000;
        1: pa = 32'hFFFF_FFFF;
        2: pa = 0;
        default: pa = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: pb = 32'hFFFF_FFFF;
        1: pb = 0;
        2: pb = $urandom_range(1, 15);
        default: pb = $urandom;
      endcase
      run_md("rnd_md", 3'($urandom_range(0, 7)), pa, pb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage_x.md
EXECUTE_STAGE_X -- requirements
Module: execute_stage_x

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  XLEN, 32, datapath width.
  MD_EN, 1, include the iterative multiply/divide unit; if 0, md_valid_e is ignored.
REQ-002 Ports, one per line: name, direction, width, meaning. Reset rst is asynchronous, active-high; clock is clk.
  clk  in  1  clock
  rst  in  1  asynchronous active-high reset
  valid_e  in  1  E-stage holds a real instruction
  flush_e  in  1  kill the E-stage instruction (mispredict or trap)
  reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e  in  1 each  control
  result_src_e  in  2  writeback select
  alu_ctrl_e  in  4  ALU op
  funct3_e  in  3  branch condition or MD op
  md_valid_e  in  1  instruction is MUL/DIV class
  rd1_e, rd2_e, imm_e, pc_e, pc4_e  in  XLEN each  operands, immediate, PC, PC+4
  rd_e  in  5  destination register
  fwd_a_e, fwd_b_e  in  2 each  forward select: 00 reg, 01 result_w, 10 alu_result_m, 11 reg
  result_w  in  XLEN  writeback value
  stall_e  out  1  E-stage busy; hazard unit holds F/D/E
  pcsrc_e  out  1  redirect taken (combinational)
  pctarget_e  out  XLEN  redirect target (combinational)
  reg_write_m, mem_write_m  out  1 each  registered control
  result_src_m  out  2  registered control
  rd_m  out  5  registered destination register
  alu_result_m, write_data_m, pc4_m  out  XLEN each  registered data

Function
REQ-003 SrcA/SrcB SHALL be selected per fwd_a_e/fwd_b_e; SrcB feeds write_data_m; the ALU B input SHALL be imm_e when alu_src_e=1.
REQ-004 ALU ops SHALL be ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA; shift amount = B[$clog2(XLEN)-1:0]; the result wraps modulo 2^XLEN; undefined codes yield 0.
REQ-005 Branch condition from funct3_e: BEQ, BNE, BLT, BGE, BLTU, BGEU on SrcA/SrcB; reserved codes are not taken.
REQ-006 pcsrc_e = valid_e & ~flush_e & (jump_e | branch_e & cond).
REQ-007 pctarget_e SHALL be (SrcA+imm_e) with bit0 cleared when jalr_e=1, else pc_e+imm_e.
REQ-008 Non-MD instructions SHALL have 1-cycle latency: EX/MEM is loaded at the next clk edge.
REQ-009 MD FSM states: IDLE, BUSY, DONE.
  IDLE->BUSY when valid_e & md_valid_e & ~flush_e; operands are latched at this transition.
  BUSY runs exactly XLEN cycles, then goes to DONE.
  DONE->IDLE after one cycle.
REQ-010 stall_e SHALL be high in the IDLE cycle that launches the MD op and throughout BUSY; low in DONE. E occupancy for an MD op = XLEN+2 cycles.
REQ-011 While stall_e=1, EX/MEM SHALL load a bubble: reg_write_m=0, mem_write_m=0, other fields hold.
REQ-012 In DONE, alu_result_m SHALL receive the MD result with the E-stage control fields.
REQ-013 MD ops by funct3_e:
  MUL (low half), MULH (signed×signed), MULHSU (signed×unsigned), MULHU (unsigned×unsigned) — high half for the MULH variants.
  DIV, DIVU, REM, REMU — restoring radix-2 division on magnitudes, sign fixed afterwards.
REQ-014 Divide by zero: quotient = all-ones, remainder = dividend.
REQ-015 Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
REQ-016 flush_e in any state SHALL abort to IDLE next cycle, drop stall_e, and load a bubble; no MD result is written.
REQ-017 flush_e together with MD issue in IDLE SHALL NOT launch the op.
REQ-018 valid_e=0 or flush_e=1 SHALL load a bubble into EX/MEM.

Reset
REQ-019 rst SHALL force the FSM to IDLE, all registered outputs and MD datapath registers to 0, and stall_e=0, asynchronously.
REQ-020 rst asserted mid-BUSY SHALL discard the operation; the first post-reset cycle accepts new instructions.

Structure
REQ-021 A shared package SHALL hold the ALU op encodings, MD funct3 encodings, branch funct3 encodings, forward-select encodings and the FSM state enum.
REQ-022 A single sub-module exe_muldiv SHALL contain the FSM and the iterative multiply/divide datapath; forwarding, ALU, branch logic and the EX/MEM register stay in the top level.

Verification
REQ-023 ADD with rd1=5, imm=7, alu_src=1 -> alu_result_m=12 next cycle; stall_e never high.
REQ-024 BLTU with SrcA=1, SrcB=0xFFFFFFFF, pc=0x100, imm=0x20 -> pcsrc_e=1 and pctarget_e=0x120 in the same cycle; BLT with the same operands -> pcsrc_e=0.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF -> after 34 cycles alu_result_m=0x80000000; DIVU 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7.
REQ-026 MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; stall_e high for exactly 33 cycles; reg_write_m=0 during the stall.
REQ-027 flush_e at BUSY cycle 10 -> stall_e low the next cycle, no MD writeback, and the following ADD completes normally.
REQ-028 fwd_a=10 with alu_result_m=9 and fwd_b=01 with result_w=3 under SUB -> alu_result_m=6; rst mid-DIV -> all outputs 0 and FSM in IDLE.
